// File: rtl/mapa_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the map RAM write-port sequencer: cell codes,
// requester IDs, FSM encoding and default map geometry.
package mapa_pkg;

  localparam int unsigned MAPA_WIDTH_DEF  = 40;
  localparam int unsigned MAPA_HEIGHT_DEF = 30;
  localparam int unsigned COORD_W_DEF     = 10;
  localparam int unsigned CELL_W          = 2;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
  localparam logic [CELL_W-1:0] CELL_COBRA = 2'b01;
  localparam logic [CELL_W-1:0] CELL_FRUTA = 2'b10;
  localparam logic [CELL_W-1:0] CELL_OBST  = 2'b11;

  typedef enum logic [1:0] {
    REQ_UPD = 2'd0,
    REQ_FRU = 2'd1,
    REQ_OBS = 2'd2
  } req_id_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter3.sv
`timescale 1ns/1ps
// Three-way round-robin arbiter: combinational one-hot grant, search starts
// at the requester after the last one granted.
module rr_arbiter3
  import mapa_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [2:0] req_i,
  output logic [2:0] gnt_c_o,
  output req_id_e    gnt_id_c_o
);

  req_id_e last_q, last_d;

  always_comb begin
    gnt_c_o    = 3'b000;
    gnt_id_c_o = REQ_UPD;
    last_d     = last_q;
    if (en_i) begin
      case (last_q)
        REQ_UPD: begin
          if (req_i[1])      begin gnt_c_o = 3'b010; gnt_id_c_o = REQ_FRU; end
          else if (req_i[2]) begin gnt_c_o = 3'b100; gnt_id_c_o = REQ_OBS; end
          else if (req_i[0]) begin gnt_c_o = 3'b001; gnt_id_c_o = REQ_UPD; end
        end
        REQ_FRU: begin
          if (req_i[2])      begin gnt_c_o = 3'b100; gnt_id_c_o = REQ_OBS; end
          else if (req_i[0]) begin gnt_c_o = 3'b001; gnt_id_c_o = REQ_UPD; end
          else if (req_i[1]) begin gnt_c_o = 3'b010; gnt_id_c_o = REQ_FRU; end
        end
        default: begin
          if (req_i[0])      begin gnt_c_o = 3'b001; gnt_id_c_o = REQ_UPD; end
          else if (req_i[1]) begin gnt_c_o = 3'b010; gnt_id_c_o = REQ_FRU; end
          else if (req_i[2]) begin gnt_c_o = 3'b100; gnt_id_c_o = REQ_OBS; end
        end
      endcase
      if (|gnt_c_o) begin
        last_d = gnt_id_c_o;
      end
    end
  end

  // Reset to OBS so the updater wins the first contended cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_OBS;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mapa_arbiter.sv
`timescale 1ns/1ps
// Map RAM write-port sequencer: raster init sweep (border = obstacle), then
// round-robin sharing of the write port between updater, fruit and obstacle.
module mapa_arbiter
  import mapa_pkg::*;
#(
  parameter int unsigned MAPA_WIDTH  = MAPA_WIDTH_DEF,
  parameter int unsigned MAPA_HEIGHT = MAPA_HEIGHT_DEF,
  parameter int unsigned COORD_W     = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_clear,
  output logic               clearing,
  input  logic               upd_req,
  input  logic [COORD_W-1:0] upd_x,
  input  logic [COORD_W-1:0] upd_y,
  input  logic [CELL_W-1:0]  upd_data,
  output logic               upd_gnt,
  input  logic               fru_req,
  input  logic [COORD_W-1:0] fru_x,
  input  logic [COORD_W-1:0] fru_y,
  output logic               fru_gnt,
  input  logic               obs_req,
  input  logic [COORD_W-1:0] obs_x,
  input  logic [COORD_W-1:0] obs_y,
  output logic               obs_gnt,
  output logic               mem_wenable,
  output logic [COORD_W-1:0] mem_wx,
  output logic [COORD_W-1:0] mem_wy,
  output logic [CELL_W-1:0]  mem_wdata,
  output logic               oob_err
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(MAPA_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(MAPA_HEIGHT - 1);
  localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(MAPA_WIDTH);
  localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(MAPA_HEIGHT);

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  cx_q, cx_d, cy_q, cy_d;
  logic                wen_q, wen_d;
  logic [COORD_W-1:0]  wx_q, wx_d, wy_q, wy_d;
  logic [CELL_W-1:0]   wdata_q, wdata_d;
  logic                oob_q, oob_d;
  logic                clearing_q, clearing_d;

  logic                arb_en;
  logic [2:0]          gnt;
  req_id_e             gnt_id;
  logic [COORD_W-1:0]  sel_x, sel_y;
  logic [CELL_W-1:0]   sel_data;
  logic                in_range;
  logic                border;

  // A start_clear in ARB suppresses granting for that cycle.
  assign arb_en = (state_q == ST_ARB) && !start_clear;

  rr_arbiter3 u_rr (
    .clk        (clk),
    .rst        (reset),
    .en_i       (arb_en),
    .req_i      ({obs_req, fru_req, upd_req}),
    .gnt_c_o    (gnt),
    .gnt_id_c_o (gnt_id)
  );

  always_comb begin
    sel_x    = upd_x;
    sel_y    = upd_y;
    sel_data = upd_data;
    case (gnt_id)
      REQ_FRU: begin sel_x = fru_x; sel_y = fru_y; sel_data = CELL_FRUTA; end
      REQ_OBS: begin sel_x = obs_x; sel_y = obs_y; sel_data = CELL_OBST;  end
      default: ;
    endcase
  end

  assign in_range = (sel_x < X_LIM) && (sel_y < Y_LIM);
  assign border   = (cx_q == '0) || (cx_q == X_LAST) || (cy_q == '0) || (cy_q == Y_LAST);

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    wen_d   = 1'b0;
    wx_d    = wx_q;
    wy_d    = wy_q;
    wdata_d = wdata_q;
    oob_d   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        wen_d   = 1'b1;
        wx_d    = cx_q;
        wy_d    = cy_q;
        wdata_d = border ? CELL_OBST : CELL_EMPTY;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          if (cy_q == Y_LAST) begin
            cy_d    = '0;
            state_d = ST_ARB;
          end else begin
            cy_d = cy_q + COORD_W'(1);
          end
        end else begin
          cx_d = cx_q + COORD_W'(1);
        end
      end
      ST_ARB: begin
        if (start_clear) begin
          state_d = ST_CLEAR;
          cx_d    = '0;
          cy_d    = '0;
        end else if (|gnt) begin
          // Out-of-range grants still consume the turn but never reach the RAM.
          if (in_range) begin
            wen_d   = 1'b1;
            wx_d    = sel_x;
            wy_d    = sel_y;
            wdata_d = sel_data;
          end else begin
            oob_d = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    clearing_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      cx_q       <= '0;
      cy_q       <= '0;
      wen_q      <= 1'b0;
      wx_q       <= '0;
      wy_q       <= '0;
      wdata_q    <= '0;
      oob_q      <= 1'b0;
      clearing_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      wen_q      <= wen_d;
      wx_q       <= wx_d;
      wy_q       <= wy_d;
      wdata_q    <= wdata_d;
      oob_q      <= oob_d;
      clearing_q <= clearing_d;
    end
  end

  assign upd_gnt     = gnt[0];
  assign fru_gnt     = gnt[1];
  assign obs_gnt     = gnt[2];
  assign clearing    = clearing_q;
  assign mem_wenable = wen_q;
  assign mem_wx      = wx_q;
  assign mem_wy      = wy_q;
  assign mem_wdata   = wdata_q;
  assign oob_err     = oob_q;

endmodule

// File: tb/tb_mapa_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mapa_arbiter: init sweep, single/contended grants,
// out-of-range requests, start_clear in ARB and async reset mid-sweep.
module tb_mapa_arbiter;

  localparam int unsigned CW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_clear = 1'b0;
  logic          clearing;
  logic          upd_req = 1'b0, fru_req = 1'b0, obs_req = 1'b0;
  logic [CW-1:0] upd_x = '0, upd_y = '0, fru_x = '0, fru_y = '0, obs_x = '0, obs_y = '0;
  logic [1:0]    upd_data = '0;
  logic          upd_gnt, fru_gnt, obs_gnt;
  logic          mem_wenable;
  logic [CW-1:0] mem_wx, mem_wy;
  logic [1:0]    mem_wdata;
  logic          oob_err;

  int n_cmp = 0;
  int n_err = 0;

  mapa_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .start_clear (start_clear),
    .clearing    (clearing),
    .upd_req     (upd_req),
    .upd_x       (upd_x),
    .upd_y       (upd_y),
    .upd_data    (upd_data),
    .upd_gnt     (upd_gnt),
    .fru_req     (fru_req),
    .fru_x       (fru_x),
    .fru_y       (fru_y),
    .fru_gnt     (fru_gnt),
    .obs_req     (obs_req),
    .obs_x       (obs_x),
    .obs_y       (obs_y),
    .obs_gnt     (obs_gnt),
    .mem_wenable (mem_wenable),
    .mem_wx      (mem_wx),
    .mem_wy      (mem_wy),
    .mem_wdata   (mem_wdata),
    .oob_err     (oob_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected write payload per requester ID in the contention phase.
  int exp_x [3] = '{1, 3, 5};
  int exp_y [3] = '{2, 4, 6};
  int exp_d [3] = '{1, 2, 3};
  int exp_id [6] = '{0, 1, 2, 0, 1, 2};

  int   wcnt, gnt_bad, clr_cycles;
  int   d00, d55, d3929, d395;
  int   lx, ly, lwen;
  bit   done;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_wen", mem_wenable, 0);
    check("rst_wx", mem_wx, 0);
    check("rst_wy", mem_wy, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_oob", oob_err, 0);
    check("rst_clearing", clearing, 1);
    check("rst_gnts", {obs_gnt, fru_gnt, upd_gnt}, 0);

    // Initial sweep
    reset = 1'b0;
    wcnt = 0; gnt_bad = 0; done = 1'b0;
    d00 = -1; d55 = -1; d3929 = -1; d395 = -1;
    lx = -1; ly = -1; lwen = -1;
    for (int c = 0; c < 1300 && !done; c++) begin
      tick();
      if (mem_wenable) begin
        wcnt++;
        if (mem_wx == 0  && mem_wy == 0)  d00   = int'(mem_wdata);
        if (mem_wx == 5  && mem_wy == 5)  d55   = int'(mem_wdata);
        if (mem_wx == 39 && mem_wy == 29) d3929 = int'(mem_wdata);
        if (mem_wx == 39 && mem_wy == 5)  d395  = int'(mem_wdata);
      end
      if (clearing && (upd_gnt || fru_gnt || obs_gnt)) gnt_bad++;
      if (!clearing) begin
        done = 1'b1;
        lx = int'(mem_wx); ly = int'(mem_wy); lwen = int'(mem_wenable);
      end
    end
    check("sweep_done", done, 1);
    check("sweep_count", wcnt, 1200);
    check("cell_0_0", d00, 3);
    check("cell_5_5", d55, 0);
    check("cell_39_29", d3929, 3);
    check("cell_39_5", d395, 3);
    check("clr_fall_x", lx, 39);
    check("clr_fall_y", ly, 29);
    check("clr_fall_wen", lwen, 1);
    check("sweep_no_gnt", gnt_bad, 0);

    // Single updater request
    upd_req = 1'b1; upd_x = 10; upd_y = 12; upd_data = 2'b01;
    #1;
    check("single_gnt", {obs_gnt, fru_gnt, upd_gnt}, 3'b001);
    tick();
    upd_req = 1'b0;
    check("single_wen", mem_wenable, 1);
    check("single_wx", mem_wx, 10);
    check("single_wy", mem_wy, 12);
    check("single_wdata", mem_wdata, 1);
    check("single_oob", oob_err, 0);

    // Out-of-range obstacle, then a normal fruit write
    obs_req = 1'b1; obs_x = 40; obs_y = 3;
    #1;
    check("oob_gnt", {obs_gnt, fru_gnt, upd_gnt}, 3'b100);
    tick();
    obs_req = 1'b0;
    check("oob_wen", mem_wenable, 0);
    check("oob_err", oob_err, 1);
    check("oob_wx_hold", mem_wx, 10);
    fru_req = 1'b1; fru_x = 3; fru_y = 3;
    #1;
    check("fru_gnt", {obs_gnt, fru_gnt, upd_gnt}, 3'b010);
    tick();
    fru_req = 1'b0;
    check("fru_wen", mem_wenable, 1);
    check("fru_wx", mem_wx, 3);
    check("fru_wy", mem_wy, 3);
    check("fru_wdata", mem_wdata, 2);
    check("oob_err_pulse", oob_err, 0);

    // Obstacle write leaves rr_last at OBS for the contention phase
    obs_req = 1'b1; obs_x = 7; obs_y = 8;
    #1;
    check("obs_gnt", {obs_gnt, fru_gnt, upd_gnt}, 3'b100);
    tick();
    obs_req = 1'b0;
    check("obs_wen", mem_wenable, 1);
    check("obs_wx", mem_wx, 7);
    check("obs_wdata", mem_wdata, 3);

    // Contention: all three held for six cycles
    upd_x = 1; upd_y = 2; upd_data = 2'b01;
    fru_x = 3; fru_y = 4;
    obs_x = 5; obs_y = 6;
    upd_req = 1'b1; fru_req = 1'b1; obs_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("cont_gnt_%0d", i), {obs_gnt, fru_gnt, upd_gnt}, 32'd1 << exp_id[i]);
      if (i > 0) begin
        check($sformatf("cont_wen_%0d", i), mem_wenable, 1);
        check($sformatf("cont_wx_%0d", i), mem_wx, exp_x[exp_id[i-1]]);
        check($sformatf("cont_wy_%0d", i), mem_wy, exp_y[exp_id[i-1]]);
        check($sformatf("cont_wdata_%0d", i), mem_wdata, exp_d[exp_id[i-1]]);
      end
      tick();
    end
    upd_req = 1'b0; fru_req = 1'b0; obs_req = 1'b0;
    check("cont_last_wx", mem_wx, 5);
    check("cont_last_wy", mem_wy, 6);
    check("cont_last_wdata", mem_wdata, 3);
    #1;
    check("idle_gnts", {obs_gnt, fru_gnt, upd_gnt}, 0);
    tick();
    check("idle_wen", mem_wenable, 0);
    check("idle_wx_hold", mem_wx, 5);
    check("idle_wy_hold", mem_wy, 6);

    // start_clear in ARB with a write in flight and upd_req pending
    fru_req = 1'b1; fru_x = 9; fru_y = 9;
    #1;
    check("pre_clr_fru_gnt", fru_gnt, 1);
    tick();
    fru_req = 1'b0;
    start_clear = 1'b1;
    upd_req = 1'b1; upd_x = 20; upd_y = 21; upd_data = 2'b01;
    #1;
    check("sc_no_gnt", {obs_gnt, fru_gnt, upd_gnt}, 0);
    check("sc_inflight_wen", mem_wenable, 1);
    check("sc_inflight_wx", mem_wx, 9);
    check("sc_inflight_wdata", mem_wdata, 2);
    tick();
    start_clear = 1'b0;
    check("sc_clearing", clearing, 1);
    check("sc_gap_wen", mem_wenable, 0);
    check("sc_gap_gnt", upd_gnt, 0);
    clr_cycles = 1;
    tick();
    check("sc_first_wen", mem_wenable, 1);
    check("sc_first_wx", mem_wx, 0);
    check("sc_first_wy", mem_wy, 0);
    check("sc_first_wdata", mem_wdata, 3);
    clr_cycles = 2; gnt_bad = 0; done = 1'b0;
    for (int c = 0; c < 1300 && !done; c++) begin
      tick();
      if (clearing) begin
        clr_cycles++;
        if (upd_gnt || fru_gnt || obs_gnt) gnt_bad++;
      end else begin
        done = 1'b1;
      end
    end
    check("sc_sweep_done", done, 1);
    check("sc_clr_cycles", clr_cycles, 1200);
    check("sc_no_gnt_while_clr", gnt_bad, 0);
    check("sc_upd_gnt_after", upd_gnt, 1);
    tick();
    upd_req = 1'b0;
    check("sc_upd_wen", mem_wenable, 1);
    check("sc_upd_wx", mem_wx, 20);
    check("sc_upd_wy", mem_wy, 21);
    check("sc_upd_wdata", mem_wdata, 1);

    // Async reset mid-sweep at (17,4)
    start_clear = 1'b1;
    tick();
    start_clear = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      tick();
      if (mem_wenable && mem_wx == 17 && mem_wy == 4) done = 1'b1;
    end
    check("ar_reach_17_4", done, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_wen", mem_wenable, 0);
    check("ar_wx", mem_wx, 0);
    check("ar_wy", mem_wy, 0);
    check("ar_wdata", mem_wdata, 0);
    check("ar_oob", oob_err, 0);
    check("ar_clearing", clearing, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("ar_restart_wen", mem_wenable, 1);
    check("ar_restart_wx", mem_wx, 0);
    check("ar_restart_wy", mem_wy, 0);
    check("ar_restart_wdata", mem_wdata, 3);
    tick();
    check("ar_second_wx", mem_wx, 1);
    check("ar_second_wy", mem_wy, 0);
    check("ar_second_wdata", mem_wdata, 3);
    tick();
    tick();
    tick();
    check("ar_fifth_wx", mem_wx, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mapa_arbiter.md
Name: mapa_arbiter

Overview:
Sequencer and write-port arbiter for the map RAM (`mapa` update write port). After reset, or on request, it sweeps the whole map to initialise it: border cells become obstacle, all others become empty. It then shares the single RAM write port round-robin among three requesters: the snake updater, the fruit placer and the obstacle placer. Sits between `update`/`fruta`/obstacle logic and `mapa.update_w*`.

Parameters:
MAPA_WIDTH, 40, map columns (cells)
MAPA_HEIGHT, 30, map rows (cells)
COORD_W, 10, coordinate width in bits

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous, active-high reset
start_clear  in  1  pulse: re-run the map initialisation sweep
clearing  out  1  high while the sweep is in progress
upd_req  in  1  snake updater write request
upd_x  in  COORD_W  updater cell x
upd_y  in  COORD_W  updater cell y
upd_data  in  2  updater cell code
upd_gnt  out  1  updater grant
fru_req  in  1  fruit write request
fru_x  in  COORD_W  fruit cell x
fru_y  in  COORD_W  fruit cell y
fru_gnt  out  1  fruit grant (cell code is fixed at 2'b10)
obs_req  in  1  obstacle write request
obs_x  in  COORD_W  obstacle cell x
obs_y  in  COORD_W  obstacle cell y
obs_gnt  out  1  obstacle grant (cell code is fixed at 2'b11)
mem_wenable  out  1  RAM write enable
mem_wx  out  COORD_W  RAM write x
mem_wy  out  COORD_W  RAM write y
mem_wdata  out  2  RAM write data
oob_err  out  1  one-cycle pulse: a granted request had out-of-range coordinates

Behaviour:
- Cell codes:
  - 00 empty
  - 01 cobra
  - 10 fruta
  - 11 obstaculo
- Reset values:
  - state is CLEAR; sweep counters are x=0, y=0.
  - mem_wenable=0; mem_wx, mem_wy, mem_wdata = 0.
  - all gnt outputs = 0; oob_err = 0; clearing = 1.
  - rr_last = OBS, so UPD has first priority.
- FSM has two states, CLEAR and ARB.
- CLEAR state:
  - Each cycle, register a write at (cx,cy).
  - Data is 11 if cx==0, cx==MAPA_WIDTH-1, cy==0 or cy==MAPA_HEIGHT-1; otherwise 00.
  - Raster order, x fastest: cx wraps at MAPA_WIDTH-1 and cy increments.
  - After the write to (MAPA_WIDTH-1, MAPA_HEIGHT-1), go to ARB next cycle and drop clearing in that same cycle.
  - The sweep is exactly MAPA_WIDTH*MAPA_HEIGHT cycles (1200 with defaults).
  - No grants are issued in CLEAR; requests wait.
  - start_clear during CLEAR is ignored (the sweep does not restart).
- ARB state:
  - Grants are combinational from req and rr_last; at most one gnt is high per cycle.
  - Search order starts at the requester after rr_last (UPD→FRU→OBS→UPD).
  - On grant, rr_last updates at the clock edge. The selected x/y/data are registered, so mem_w* is valid exactly 1 cycle after gnt, with mem_wenable=1 for that one cycle.
  - Sustained throughput is one write per cycle.
  - Requester handshake: hold req, x, y and data stable until the cycle gnt is high. Drop req after that cycle, or keep it high for a further write.
  - Out-of-range request (x≥MAPA_WIDTH or y≥MAPA_HEIGHT): it is still granted, which consumes its turn. No write occurs (mem_wenable=0) and oob_err pulses 1 cycle later.
  - start_clear in ARB:
    - No grant is issued in that cycle.
    - A write registered from the previous cycle's grant still completes.
    - Next state is CLEAR with counters at 0.
- No requests: mem_wenable=0; mem_w* holds its last value.
- Reset asserted mid-operation: all outputs return to reset values immediately; any in-flight write is lost.

Decomposition:
- Shared package (mapa_pkg):
  - cell codes CELL_EMPTY, CELL_COBRA, CELL_FRUTA, CELL_OBST
  - requester IDs REQ_UPD, REQ_FRU, REQ_OBS
  - state encoding
  - default map dimensions
- One natural sub-module, rr_arbiter3: 3-way round-robin grant with a last-grant register.
- The clear sweep and output register stay in the top.

Test Plan:
- Reset sweep: release reset, no requests.
  - Exactly 1200 mem_wenable cycles.
  - (0,0)=11, (5,5)=00, (39,29)=11, (39,5)=11.
  - clearing falls on the cycle after the write to (39,29); no gnt while clearing.
- Single request: in ARB, upd_req with (10,12,01).
  - upd_gnt=1 in the same cycle.
  - Next cycle: mem_wenable=1, wx=10, wy=12, wdata=01.
- Contention: all three reqs held high for 6 cycles from rr_last=OBS.
  - Grants in order UPD, FRU, OBS, UPD, FRU, OBS; one per cycle.
  - fru writes carry data 10; obs writes carry data 11.
- Out of range: obs_req at (40,3).
  - obs_gnt=1; next cycle mem_wenable=0 and oob_err=1 for one cycle.
  - A following fru_req (3,3) writes normally.
- start_clear while upd_req is high in ARB:
  - No gnt that cycle; clearing=1 next cycle; sweep starts at (0,0).
  - upd_gnt appears only 1200 cycles later.
- Async reset mid-sweep at (17,4):
  - Outputs zero immediately; clearing=1.
  - After release, the sweep restarts at (0,0).
